// File: rtl/sr_cmd_seq_pkg.sv
// Shared op-code and state encodings for the sr_cmd_seq command sequencer
// and anything else that talks to an srff bank driver.
package sr_cmd_seq_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_CLR = 2'b01,
    OP_SET = 2'b10,
    OP_TGL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_INIT   = 2'b00,
    ST_IDLE   = 2'b01,
    ST_DRIVE  = 2'b10,
    ST_SETTLE = 2'b11
  } state_e;

endpackage

// File: rtl/sr_cmd_seq_if.sv
// Command handshake between an upstream issuer and sr_cmd_seq, plus the
// retire/reject status pulses returned to the issuer.
interface sr_cmd_seq_if #(
  parameter int unsigned IDXW = 2
) ();

  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [IDXW-1:0] cmd_idx;
  logic            done;
  logic            err;

  modport master (
    output cmd_valid, cmd_op, cmd_idx,
    input  cmd_ready, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_idx,
    output cmd_ready, done, err
  );

endinterface

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter that parks at zero; times the INIT, DRIVE and
// SETTLE phases of sr_cmd_seq.
module sr_pulse_timer #(
  parameter int unsigned   TW      = 1,
  parameter logic [TW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          zero_c
);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/sr_cmd_seq.sv
// Command sequencer for a bank of srff cells: turns set/clear/toggle commands
// into registered, HOLD-wide s/r pulses. Define SR_CMD_TOGGLE_EN to enable op 11.
module sr_cmd_seq
  import sr_cmd_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned IDXW   = 2,
  parameter int unsigned HOLD   = 1,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  sr_cmd_seq_if.slave      bus,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] shadow
);

  localparam int unsigned TMAX = (HOLD > SETTLE) ? HOLD : SETTLE;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int unsigned NIDX = 1 << IDXW;
  // One bit per encodable index, set where the index names a real cell.
  localparam logic [NIDX-1:0] IDX_OK = NIDX'((64'(1) << WIDTH) - 64'(1));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] s_d, r_d, shadow_d;
  logic             done_q, done_d, err_q, err_d;
  logic             tmr_load, tmr_zero;
  logic [TW-1:0]    tmr_val;
  logic [WIDTH-1:0] onehot;
  logic             idx_ok, accept;
  op_e              op;

  sr_pulse_timer #(
    .TW      (TW),
    .RST_VAL (TW'(HOLD - 1))
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero_c   (tmr_zero)
  );

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      s       <= '0;
      r       <= '0;
      shadow  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s       <= s_d;
      r       <= r_d;
      shadow  <= shadow_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state, command decode and pulse shaping
  always_comb begin
    state_d  = state_q;
    s_d      = s;
    r_d      = r;
    shadow_d = shadow;
    done_d   = 1'b0;
    err_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = TW'(HOLD - 1);
    op       = op_e'(bus.cmd_op);
    onehot   = WIDTH'(1) << bus.cmd_idx;
    idx_ok   = IDX_OK[bus.cmd_idx];
    accept   = bus.cmd_valid && (state_q == ST_IDLE);

    case (state_q)
      ST_INIT: begin
        // r is still zero only in the first cycle after reset release.
        if (r == '0) begin
          r_d      = '1;
          tmr_load = 1'b1;
        end else if (tmr_zero) begin
          r_d     = '0;
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (accept) begin
          if (op == OP_NOP) begin
            done_d = 1'b1;
          end else if (!idx_ok) begin
            err_d = 1'b1;
          end else begin
            case (op)
              OP_SET: begin
                s_d      = onehot;
                shadow_d = shadow | onehot;
              end
              OP_CLR: begin
                r_d      = onehot;
                shadow_d = shadow & ~onehot;
              end
              default: begin
`ifdef SR_CMD_TOGGLE_EN
                if ((shadow & onehot) != '0) r_d = onehot;
                else                         s_d = onehot;
                shadow_d = shadow ^ onehot;
`else
                err_d = 1'b1;
`endif
              end
            endcase
            if ((s_d | r_d) != '0) begin
              state_d  = ST_DRIVE;
              tmr_load = 1'b1;
            end
          end
        end
      end

      ST_DRIVE: begin
        if (tmr_zero) begin
          s_d = '0;
          r_d = '0;
          if (SETTLE > 0) begin
            state_d  = ST_SETTLE;
            tmr_load = 1'b1;
            tmr_val  = TW'((SETTLE > 0) ? SETTLE - 1 : 0);
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      ST_SETTLE: begin
        if (tmr_zero) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

endmodule
